// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES/SNES multi-pad serial reader.
//   nes_state_t : frame sequencer states (IDLE, LATCH, PULSE_HI, PULSE_LO, DONE)
//   BTN_*       : bit positions of the NES buttons inside one pad's slice of the
//                 button vector (the first bit shifted out, A, lands in the MSB)
// -----------------------------------------------------------------------------
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_HI,
        PULSE_LO,
        DONE
    } nes_state_t;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_pad_shift.sv
// -----------------------------------------------------------------------------
// nes_pad_shift
// Per-pad datapath: 2-flop synchroniser on the active-low serial line, a
// BITS-wide shift register that collects one frame, and the committed
// (active-high) button state with its press-edge vector.
// Optional feature macro: NES_DEBOUNCE_EN -- a frame is committed only when it
// matches the previous raw frame of the same pad.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   data_n_i   in   serial data from the pad, active-low, asynchronous
//   shift_i    in   sample the synchronised bit into the shift register
//   commit_i   in   publish the collected frame on the next edge
//   buttons_o  out  committed button state, active-high, first bit in MSB
//   pressed_o  out  0->1 transitions of buttons_o, high only after a commit
// -----------------------------------------------------------------------------
module nes_pad_shift
    import nes_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data_n_i,
    input  logic            shift_i,
    input  logic            commit_i,
    output logic [BITS-1:0] buttons_o,
    output logic [BITS-1:0] pressed_o
);

    logic [1:0]      sync_q;
    logic [BITS-1:0] raw_q;
    logic [BITS-1:0] buttons_q;
    logic [BITS-1:0] pressed_q;
    logic [BITS-1:0] buttons_d;

`ifdef NES_DEBOUNCE_EN
    logic [BITS-1:0] prev_raw_q;

    // Reset to the released pattern so an idle pad commits on its first frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_raw_q <= '1;
        end else if (commit_i) begin
            prev_raw_q <= raw_q;
        end
    end

    // A slice only moves when two consecutive frames agree.
    assign buttons_d = (raw_q == prev_raw_q) ? ~raw_q : buttons_q;
`else
    assign buttons_d = ~raw_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours (the synchroniser and shift chain
    // would collapse into one stage with blocking assignments).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;   // line idles high; avoids a phantom press
            raw_q     <= '1;
            buttons_q <= '0;
            pressed_q <= '0;
        end else begin
            sync_q <= {sync_q[0], data_n_i};
            // Shift left: after BITS samples the first bit (A) sits in the MSB.
            if (shift_i) begin
                raw_q <= {raw_q[BITS-2:0], sync_q[1]};
            end
            pressed_q <= commit_i ? (buttons_d & ~buttons_q) : '0;
            if (commit_i) begin
                buttons_q <= buttons_d;
            end
        end
    end

    assign buttons_o = buttons_q;
    assign pressed_o = pressed_q;

endmodule

// File: rtl/nes_multi_pad_reader.sv
// -----------------------------------------------------------------------------
// nes_multi_pad_reader
// Polls NUM_PADS NES/SNES pads on a shared latch/pulse bus. A programmable
// tick (CLK_DIV clocks) paces the frame: POLL_TICKS idle ticks, a 2-tick latch,
// then BITS-1 pulse high/low tick pairs, then a 1-cycle commit.
// Optional feature macro: NES_DEBOUNCE_EN (implemented in nes_pad_shift).
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   poll_en      in   1 = keep polling; 0 = finish current frame then idle
//   nes_data     in   [NUM_PADS] serial data, active-low, asynchronous
//   nes_latch    out  latch to all pads
//   nes_pulse    out  shift clock to all pads
//   buttons      out  [NUM_PADS*BITS] committed state, pad p at [p*BITS +: BITS]
//   pressed      out  [NUM_PADS*BITS] press edges, valid with frame_valid
//   frame_valid  out  one-cycle strobe when buttons/pressed update
//   busy         out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module nes_multi_pad_reader
    import nes_pkg::*;
#(
    parameter int NUM_PADS   = 2,
    parameter int BITS       = 8,
    parameter int CLK_DIV    = 60,
    parameter int POLL_TICKS = 2778
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     poll_en,
    input  logic [NUM_PADS-1:0]      nes_data,
    output logic                     nes_latch,
    output logic                     nes_pulse,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic [NUM_PADS*BITS-1:0] pressed,
    output logic                     frame_valid,
    output logic                     busy
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int IDLE_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam int BIT_W  = $clog2(BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(POLL_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS - 1);

    nes_state_t        state_q, state_d;
    logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              latch_q, pulse_q, valid_q;
    logic              tick;
    logic              shift;
    logic              commit;

    assign tick = (tick_cnt_q == DIV_LAST);

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        shift      = 1'b0;
        commit     = 1'b0;

        case (state_q)
            IDLE: begin
                // Idle count saturates at its last value while polling is off,
                // so a new frame starts on the first tick after poll_en rises.
                if (tick) begin
                    if (idle_cnt_q != IDLE_LAST) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end else if (poll_en) begin
                        idle_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = LATCH;
                    end
                end
            end
            LATCH: begin
                // bit_cnt doubles as the 2-tick latch phase counter.
                if (tick) begin
                    if (bit_cnt_q == '0) begin
                        bit_cnt_d = BIT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        shift     = 1'b1;
                        state_d   = PULSE_HI;
                    end
                end
            end
            PULSE_HI: begin
                if (tick) begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = PULSE_LO;
                end
            end
            PULSE_LO: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        commit  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = PULSE_HI;
                    end
                end
            end
            DONE: begin
                // Restart the time base so every frame has the same length.
                tick_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            idle_cnt_q <= '0;
            bit_cnt_q  <= '0;
            latch_q    <= 1'b0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            // Registered from next state: glitch-free pins aligned with state_q.
            latch_q    <= (state_d == LATCH);
            pulse_q    <= (state_d == PULSE_HI);
            valid_q    <= commit;
        end
    end

    assign nes_latch   = latch_q;
    assign nes_pulse   = pulse_q;
    assign frame_valid = valid_q;
    assign busy        = (state_q != IDLE);

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        nes_pad_shift #(
            .BITS (BITS)
        ) u_pad (
            .clk       (clk),
            .rst       (rst),
            .data_n_i  (nes_data[p]),
            .shift_i   (shift),
            .commit_i  (commit),
            .buttons_o (buttons[p*BITS +: BITS]),
            .pressed_o (pressed[p*BITS +: BITS])
        );
    end

endmodule

// File: tb/tb_nes_multi_pad_reader.sv
// -----------------------------------------------------------------------------
// tb_nes_multi_pad_reader
// Directed bench for nes_multi_pad_reader: an 8-bit/2-pad instance and a
// 16-bit/3-pad instance (CLK_DIV=4, POLL_TICKS=3), each fed by a behavioural
// pad that reloads on latch and advances on every rising pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nes_multi_pad_reader;
    import nes_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int POLL_TICKS = 3;
    localparam int PERIOD8    = 77;   // (3+2+14)*4+1
    localparam int PERIOD16   = 141;  // (3+2+30)*4+1

`ifdef NES_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    localparam logic [7:0] AS_SET = 8'h90;   // A + Start, active-high
    localparam logic [7:0] AS_N   = 8'h6F;   // serial 0,1,1,0,1,1,1,1
    localparam logic [7:0] B_N    = 8'hBF;   // only B held

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic poll_en = 1'b1;

    logic [1:0]  data8;
    logic        latch8, pulse8, fv8, busy8;
    logic [15:0] buttons8, pressed8;
    logic [2:0]  data16;
    logic        latch16, pulse16, fv16, busy16;
    logic [47:0] buttons16, pressed16;

    logic [7:0]  pat8  [2];
    logic [15:0] pat16 [3];
    int idx8  = 0;
    int idx16 = 0;

    int tests_run    = 0;
    int tests_failed = 0;
    int stray        = 0;
    logic [15:0] prev_b8  = '0;
    logic        prev_fv8 = 1'b0;

    always #5 clk = ~clk;

    nes_multi_pad_reader #(
        .NUM_PADS(2), .BITS(8), .CLK_DIV(CLK_DIV), .POLL_TICKS(POLL_TICKS)
    ) dut8 (
        .clk(clk), .rst(rst), .poll_en(poll_en), .nes_data(data8),
        .nes_latch(latch8), .nes_pulse(pulse8), .buttons(buttons8),
        .pressed(pressed8), .frame_valid(fv8), .busy(busy8)
    );

    nes_multi_pad_reader #(
        .NUM_PADS(3), .BITS(16), .CLK_DIV(CLK_DIV), .POLL_TICKS(POLL_TICKS)
    ) dut16 (
        .clk(clk), .rst(rst), .poll_en(poll_en), .nes_data(data16),
        .nes_latch(latch16), .nes_pulse(pulse16), .buttons(buttons16),
        .pressed(pressed16), .frame_valid(fv16), .busy(busy16)
    );

    // Pad model: latch reloads bit 0, each rising pulse exposes the next bit,
    // and an exhausted register reads 1.
    always @(posedge latch8 or posedge pulse8) begin
        if (latch8) idx8 = 0;
        else        idx8 = idx8 + 1;
    end
    always @(posedge latch16 or posedge pulse16) begin
        if (latch16) idx16 = 0;
        else         idx16 = idx16 + 1;
    end
    always_comb begin
        for (int p = 0; p < 2; p++)
            data8[p] = (idx8 < 8) ? pat8[p][3'(7 - idx8)] : 1'b1;
        for (int p = 0; p < 3; p++)
            data16[p] = (idx16 < 16) ? pat16[p][4'(15 - idx16)] : 1'b1;
    end

    // buttons may only move and pressed may only be non-zero in a frame_valid
    // cycle; frame_valid is never longer than one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!fv8 && (pressed8 != '0 || buttons8 != prev_b8)) stray++;
            if (fv8 && prev_fv8) stray++;
        end
        prev_b8  = buttons8;
        prev_fv8 = fv8;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns the number of negedges until frame_valid is seen, or -1.
    task automatic wait_fv8(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (fv8) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Frame table for the press/release and debounce sequence.
    logic [7:0]  f_pad0 [6] = '{8'hFF, 8'hBF, 8'hFF, 8'hBF, 8'hFF, 8'hFF};
    logic [7:0]  f_pad1 [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hBF};
    logic [15:0] nd_btn [6] = '{16'h0000, 16'h0040, 16'h0000, 16'h0040, 16'h4000, 16'h4000};
    logic [15:0] nd_prs [6] = '{16'h0000, 16'h0040, 16'h0000, 16'h0040, 16'h4000, 16'h0000};
    logic [15:0] db_btn [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000};

    initial begin
        int latch_first = -1, latch_len = 0, pulse_cnt = 0, pulse_hi = 0, fv_n = 0;
        int fv_cyc [2] = '{-1, -1};
        logic [15:0] fv_btn [2] = '{16'hx, 16'hx};
        logic [15:0] fv_prs [2] = '{16'hx, 16'hx};
        int fv16_cyc = -1;
        logic [47:0] fv16_btn = 'x;
        logic prev_pulse = 1'b0;
        logic busy11 = 1'bx, busy12 = 1'bx;
        int c, act, lat, falls;

        pat8[0] = AS_N;
        pat8[1] = 8'hFF;
        pat16[0] = 16'hFFFF;
        pat16[1] = 16'hFFFF;
        pat16[2] = 16'hFFFE;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl8", {latch8, pulse8, fv8, busy8}, 4'b0000);
        check("rst_btn8", {buttons8, pressed8}, 32'h0);
        check("rst_all16", {latch16, pulse16, fv16, busy16, buttons16, pressed16}, 100'h0);

        // ---- first frames: timing and A+Start on pad 0 ----
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 160; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (latch8 && latch_first < 0) latch_first = cyc;
            if (cyc < PERIOD8) begin
                if (latch8) latch_len++;
                if (pulse8) pulse_hi++;
                if (pulse8 && !prev_pulse) pulse_cnt++;
            end
            prev_pulse = pulse8;
            if (cyc == 11) busy11 = busy8;
            if (cyc == 12) busy12 = busy8;
            if (fv8) begin
                if (fv_n < 2) begin
                    fv_cyc[fv_n] = cyc;
                    fv_btn[fv_n] = buttons8;
                    fv_prs[fv_n] = pressed8;
                end
                fv_n++;
            end
            if (fv16 && fv16_cyc < 0) begin
                fv16_cyc = cyc;
                fv16_btn = buttons16;
            end
        end
        check("latch_start", latch_first, 12);
        check("latch_len", latch_len, 8);
        check("pulse_count", pulse_cnt, 7);
        check("pulse_high_cycles", pulse_hi, 28);
        check("busy_before_latch", busy11, 1'b0);
        check("busy_at_latch", busy12, 1'b1);
        check("fv_first", fv_cyc[0], PERIOD8 - 1);
        check("fv_second", fv_cyc[1], 2 * PERIOD8 - 1);
        check("fv_count", fv_n, 2);
        check("f1_buttons", fv_btn[0], DB ? 16'h0000 : {8'h00, AS_SET});
        check("f1_pressed", fv_prs[0], DB ? 16'h0000 : {8'h00, AS_SET});
        check("f2_buttons", fv_btn[1], {8'h00, AS_SET});
        check("f2_pressed", fv_prs[1], DB ? {8'h00, AS_SET} : 16'h0000);
        check("w16_fv_first", fv16_cyc, PERIOD16 - 1);
        check("w16_buttons", fv16_btn, DB ? 48'h0 : 48'h0001_0000_0000);

        // ---- move A+Start to pad 1, release pad 0 ----
        pat8[0] = 8'hFF;
        pat8[1] = AS_N;
        wait_fv8(200, c);
        check("f3_seen", c > 0, 1'b1);
        check("f3_buttons", buttons8, DB ? {8'h00, AS_SET} : {AS_SET, 8'h00});
        check("f3_pressed", pressed8, DB ? 16'h0000 : {AS_SET, 8'h00});
        wait_fv8(200, c);
        check("f4_period", c, PERIOD8);
        check("f4_buttons", buttons8, {AS_SET, 8'h00});
        check("f4_pressed", pressed8, DB ? {AS_SET, 8'h00} : 16'h0000);

        // ---- poll_en dropped during PULSE_HI ----
        c = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (pulse8) begin
                c = i;
                break;
            end
        end
        check("pulse_seen", c > 0, 1'b1);
        poll_en = 1'b0;
        wait_fv8(200, c);
        check("drop_frame_done", c > 0, 1'b1);
        @(negedge clk);
        check("drop_busy_low", busy8, 1'b0);
        act = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (latch8 || fv8 || busy8) act++;
        end
        check("drop_idle_activity", act, 0);
        poll_en = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (latch8) begin
                lat = i;
                break;
            end
        end
        check("resume_latency_ok", lat >= 1 && lat <= CLK_DIV, 1'b1);

        // ---- asynchronous reset in PULSE_LO after the fourth pulse ----
        falls = 0;
        prev_pulse = pulse8;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pulse8 && prev_pulse) falls++;
            prev_pulse = pulse8;
            if (falls == 4) break;
        end
        check("mid_fall_count", falls, 4);
        check("mid_pre_buttons", buttons8, {AS_SET, 8'h00});
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pins", {latch8, pulse8, busy8, fv8}, 4'b0000);
        check("mid_rst_buttons", buttons8, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_fv8(200, c);
        check("post_rst_fv", c, PERIOD8 - 1);
        check("post_rst_buttons", buttons8, DB ? 16'h0000 : {AS_SET, 8'h00});
        check("post_rst_pressed", pressed8, DB ? 16'h0000 : {AS_SET, 8'h00});

        // ---- B press/release sequence (debounce behaviour when enabled) ----
        for (int f = 0; f < 6; f++) begin
            pat8[0] = f_pad0[f];
            pat8[1] = f_pad1[f];
            wait_fv8(200, c);
            check($sformatf("seq%0d_seen", f), c > 0, 1'b1);
            check($sformatf("seq%0d_buttons", f), buttons8, DB ? db_btn[f] : nd_btn[f]);
            check($sformatf("seq%0d_pressed", f), pressed8, DB ? db_btn[f] : nd_prs[f]);
        end

        check("stray_events", stray, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
